// File: rtl/hs_pkg.sv
// Shared definitions for the four-phase req/ack handshake pair (transmitter and receiver).
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        REL   = 2'd2,
        DRAIN = 2'd3
    } hs_state_e;

    localparam int unsigned SYNC_MIN = 2;
    localparam int unsigned SYNC_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// Plain DFF synchroniser chain for a single asynchronous bit; each stage is an
// ordinary flop so metastability models can be substituted per stage.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic CK,
    input  logic RS,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;

    always_ff @(posedge CK) begin
        if (RS) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/hs4_tx.sv
// Launching side of the four-phase req/ack CDC handshake: captures a word from a
// valid/ready source, holds it on tx_data and runs req against a synchronised ack.
module hs4_tx
    import hs_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 0,
    parameter int unsigned TO_W        = 16
) (
    input  logic             CK,
    input  logic             RS,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             ack,
    output logic             done,
    output logic             err
);

    // Out-of-range chain lengths are clamped to the supported range.
    localparam int unsigned SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                                     (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    hs_state_e        state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic             err_q, err_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]  cnt_inc;
    logic             waiting;
    logic             ack_s;

    sync_chain #(
        .STAGES(SYNC_N)
    ) u_ack_sync (
        .CK(CK),
        .RS(RS),
        .d (ack),
        .q (ack_s)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        tx_d     = tx_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // A stale ack must be seen low before a new request goes out.
                    if (ack_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        tx_d    = in_data;
                    end
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = REL;
                    req_d   = 1'b0;
                end
            end
            REL: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            DRAIN: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Threshold is judged on the incremented value so err can rise on the same
    // edge as a state advance that clears the counter.
    always_comb begin
        waiting = (state_q != IDLE);
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (state_d != state_q || !waiting) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
        err_d = err_q | (waiting && (TIMEOUT != 0) && (cnt_inc == TO_LIMIT));
    end

    always_ff @(posedge CK) begin
        if (RS) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            tx_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req     = req_q;
    assign tx_data = tx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_hs4_tx.sv
// Directed and randomised bench for hs4_tx: one instance with a 2-flop ack chain and
// timeout, one with a 4-flop chain for the latency sweep.
module tb_hs4_tx;

    localparam int SA = 2;
    localparam int SB = 4;
    localparam int TO = 10;

    logic       CK = 1'b0;
    logic       RS;
    logic [7:0] in_data;
    logic       in_valid;

    logic       a_ready, a_req, a_ack, a_done, a_err;
    logic [7:0] a_tx;
    logic       b_ready, b_req, b_ack, b_done, b_err;
    logic [7:0] b_tx;

    always #5 CK = ~CK;

    hs4_tx #(.WIDTH(8), .SYNC_STAGES(SA), .TIMEOUT(TO), .TO_W(16)) dut_a (
        .CK(CK), .RS(RS), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
        .req(a_req), .tx_data(a_tx), .ack(a_ack), .done(a_done), .err(a_err)
    );

    hs4_tx #(.WIDTH(8), .SYNC_STAGES(SB), .TIMEOUT(0), .TO_W(16)) dut_b (
        .CK(CK), .RS(RS), .in_data(in_data), .in_valid(in_valid), .in_ready(b_ready),
        .req(b_req), .tx_data(b_tx), .ack(b_ack), .done(b_done), .err(b_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit echo   = 1'b1;
    int dly    = 0;
    bit hist [0:63];
    int ack_rise_c = 0;
    int ack_fall_c = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder for dut_a: ack is req delayed by dly cycles when echo is on.
    task automatic tick();
        logic prev;
        @(posedge CK);
        #1;
        cyc++;
        hist[cyc % 64] = a_req;
        prev = a_ack;
        if (echo) a_ack = (cyc >= dly) ? hist[(cyc - dly) % 64] : 1'b0;
        if (a_ack && !prev) ack_rise_c = cyc;
        if (!a_ack && prev) ack_fall_c = cyc;
        b_ack = b_req;
    endtask

    task automatic stream(input int n, input bit rnd);
        logic [7:0] exp_q[$];
        logic [7:0] held = 8'h00;
        logic [7:0] w;
        bit   busy = 1'b0;
        logic req_prev;
        int   acc = 0, dn = 0, bad = 0, guard = 0;
        w = rnd ? 8'($urandom) : 8'd1;
        exp_q.push_back(w);
        in_data  = w;
        in_valid = 1'b1;
        req_prev = a_req;
        while (dn < n && guard < 400) begin
            if (rnd && a_ready) dly = $urandom_range(0, 3);
            tick();
            guard++;
            if (a_req && !req_prev) begin
                acc++;
                if (exp_q.size() > 0) chk("tx_word", a_tx, exp_q.pop_front());
                else chk("extra_accept", acc, n);
                held = a_tx;
                busy = 1'b1;
                if (acc < n) begin
                    w = rnd ? 8'($urandom) : 8'(acc + 1);
                    exp_q.push_back(w);
                    in_data = w;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (!a_req && req_prev) chk("req_fall_lat", cyc - ack_rise_c, SA + 1);
            if (busy && a_tx !== held) bad++;
            if (a_done) begin
                dn++;
                busy = 1'b0;
                chk("done_lat", cyc - ack_fall_c, SA);
            end
            req_prev = a_req;
        end
        chk("xfer_count", dn, n);
        chk("accept_count", acc, n);
        chk("tx_stable", bad, 0);
        tick();
        chk("done_one_cycle", a_done, 1'b0);
        chk("ready_after_done", a_ready, 1'b1);
    endtask

    initial begin
        int t1;
        RS = 1'b1; in_valid = 1'b0; in_data = 8'h00; a_ack = 1'b0; b_ack = 1'b0;
        tick();
        tick();
        chk("rst_req", a_req, 1'b0);
        chk("rst_tx", a_tx, 8'h00);
        chk("rst_done", a_done, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_b_req", b_req, 1'b0);
        RS = 1'b0;
        tick();

        // Single transfer on both instances with an immediate echo responder.
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s1_a_tx", a_tx, 8'hA5);
        chk("s1_a_req", a_req, 1'b1);
        chk("s1_b_tx", b_tx, 8'hA5);
        chk("s1_b_req", b_req, 1'b1);
        for (int k = 2; k <= 13; k++) begin
            tick();
            chk("s1_a_req_k", a_req, (k < SA + 2));
            chk("s1_a_done_k", a_done, (k == 2 * SA + 2));
            chk("s1_a_ready_k", a_ready, (k >= 2 * SA + 3));
            chk("s1_b_req_k", b_req, (k < SB + 2));
            chk("s1_b_done_k", b_done, (k == 2 * SB + 2));
            chk("s1_b_ready_k", b_ready, (k >= 2 * SB + 3));
        end

        // Back-to-back with in_valid held, then a randomised run.
        stream(2, 1'b0);
        stream(12, 1'b1);
        chk("rand_no_err", a_err, 1'b0);
        dly = 0;

        // Slow responder: ack held off well past the timeout.
        echo = 1'b0; a_ack = 1'b0;
        in_data = 8'h77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        t1 = cyc;
        chk("s3_req_up", a_req, 1'b1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 9) chk("s3_err_before", a_err, 1'b0);
            if (k == 10) chk("s3_err_at", a_err, 1'b1);
            if (k == 15) chk("s3_still_req", a_req, 1'b1);
        end
        chk("s3_elapsed", cyc - t1, 19);
        a_ack = 1'b1;
        for (int k = 1; k <= SA + 1; k++) begin
            tick();
            chk("s3_req_fall", a_req, (k <= SA));
        end
        a_ack = 1'b0;
        for (int k = 1; k <= SA; k++) begin
            tick();
            chk("s3_done", a_done, (k == SA));
        end
        tick();
        chk("s3_ready", a_ready, 1'b1);
        chk("s3_err_sticky", a_err, 1'b1);

        // Reset while requesting with ack high, then drain of the stale ack.
        in_data = 8'hC3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s4_req_up", a_req, 1'b1);
        a_ack = 1'b1; RS = 1'b1;
        tick();
        chk("s4_rst_req", a_req, 1'b0);
        chk("s4_rst_tx", a_tx, 8'h00);
        chk("s4_rst_err", a_err, 1'b0);
        RS = 1'b0;
        for (int k = 0; k < SA; k++) tick();
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s4_drain_req", a_req, 1'b0);
        chk("s4_drain_ready", a_ready, 1'b0);
        a_ack = 1'b0;
        for (int k = 0; k < SA; k++) tick();
        chk("s4_drain_hold", a_ready, 1'b0);
        chk("s4_drain_noreq", a_req, 1'b0);
        tick();
        chk("s4_back_idle", a_ready, 1'b1);
        echo = 1'b1; dly = 0;
        stream(1, 1'b0);

        // Ack glitch while idle must be ignored.
        echo = 1'b0; a_ack = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) a_ack = 1'b0;
            tick();
            chk("s5_req", a_req, 1'b0);
            chk("s5_done", a_done, 1'b0);
            chk("s5_ready", a_ready, 1'b1);
            chk("s5_err", a_err, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
